// File: rtl/cpu_run_ctrl.sv
// Run controller: streams a program into instruction memory with the CPU held,
// then releases the CPU until it fetches a halt word or reaches a cycle limit.
module cpu_run_ctrl #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'h0000000C
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_waddr,
    output logic [DATA_WIDTH-1:0] im_wdata,
    output logic                  cpu_reset,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic [CNT_WIDTH-1:0]  cycle_limit,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            halt_cause,
    output logic [CNT_WIDTH-1:0]  cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_HALT  = 2'd1;
    localparam logic [1:0] CAUSE_LIMIT = 2'd2;
    localparam logic [1:0] CAUSE_OVF   = 2'd3;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [CNT_WIDTH-1:0]    cycles_q, cycles_d;
    logic [1:0]              cause_q, cause_d;
    logic                    load_ready_q, load_ready_d;
    logic                    cpu_reset_q, cpu_reset_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    handshake;
    logic [CNT_WIDTH-1:0]    cycles_inc;

    assign handshake  = load_valid & load_ready_q;
    assign cycles_inc = cycles_q + CNT_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        cycles_d = cycles_q;
        cause_d  = cause_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = LOAD;
                    waddr_d  = '0;
                    cycles_d = '0;
                    cause_d  = CAUSE_NONE;
                end
            end
            LOAD: begin
                if (handshake) begin
                    waddr_d = waddr_q + ADDR_WIDTH'(1);
                    // A last word landing on the top address is a normal load.
                    if (load_last) begin
                        state_d = RUN;
                    end else if (waddr_q == '1) begin
                        state_d = DONE;
                        cause_d = CAUSE_OVF;
                    end
                end
            end
            RUN: begin
                if (instr == HALT_INSTR) begin
                    state_d = DONE;
                    cause_d = CAUSE_HALT;
                end else begin
                    if (cycles_q != '1) begin
                        cycles_d = cycles_inc;
                    end
                    if ((cycle_limit != '0) && (cycles_inc == cycle_limit)) begin
                        state_d = DONE;
                        cause_d = CAUSE_LIMIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are plain flops.
    always_comb begin
        load_ready_d = (state_d == LOAD);
        cpu_reset_d  = (state_d == RUN);
        busy_d       = (state_d == LOAD) || (state_d == RUN);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            waddr_q      <= '0;
            cycles_q     <= '0;
            cause_q      <= CAUSE_NONE;
            load_ready_q <= 1'b0;
            cpu_reset_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            cycles_q     <= cycles_d;
            cause_q      <= cause_d;
            load_ready_q <= load_ready_d;
            cpu_reset_q  <= cpu_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign im_we      = handshake;
    assign im_waddr   = waddr_q;
    assign im_wdata   = load_data;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign halt_cause = cause_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl with a tiny fetch/execute CPU stub (addi, add, j).
module tb_cpu_run_ctrl;

    localparam int AW  = 5;
    localparam int AW2 = 2;
    localparam int DW  = 32;
    localparam int CW  = 16;

    logic          clock       = 1'b0;
    logic          reset       = 1'b1;
    logic          start       = 1'b0;
    logic          start2      = 1'b0;
    logic          load_valid  = 1'b0;
    logic          load_valid2 = 1'b0;
    logic [DW-1:0] load_data   = '0;
    logic          load_last   = 1'b0;
    logic [CW-1:0] cycle_limit = '0;
    logic [DW-1:0] instr;

    logic          load_ready, im_we, cpu_reset, busy, done;
    logic [AW-1:0] im_waddr;
    logic [DW-1:0] im_wdata;
    logic [1:0]    halt_cause;
    logic [CW-1:0] cycles;

    logic           load_ready2, im_we2, cpu_reset2, busy2, done2;
    logic [AW2-1:0] im_waddr2;
    logic [DW-1:0]  im_wdata2;
    logic [1:0]     halt_cause2;
    logic [CW-1:0]  cycles2;

    always #5 clock = ~clock;

    cpu_run_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .HALT_INSTR(32'h0000000C)) u_dut (
        .clock(clock), .reset(reset), .start(start),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
        .cpu_reset(cpu_reset), .instr(instr), .cycle_limit(cycle_limit),
        .busy(busy), .done(done), .halt_cause(halt_cause), .cycles(cycles)
    );

    cpu_run_ctrl #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .HALT_INSTR(32'h0000000C)) u_dut2 (
        .clock(clock), .reset(reset), .start(start2),
        .load_valid(load_valid2), .load_ready(load_ready2), .load_data(load_data), .load_last(load_last),
        .im_we(im_we2), .im_waddr(im_waddr2), .im_wdata(im_wdata2),
        .cpu_reset(cpu_reset2), .instr(instr), .cycle_limit(cycle_limit),
        .busy(busy2), .done(done2), .halt_cause(halt_cause2), .cycles(cycles2)
    );

    // CPU stub: instruction memory plus a minimal execute stage
    logic [DW-1:0] imem [0:31];
    logic [DW-1:0] gpr  [0:31];
    logic [AW-1:0] pc;

    initial begin
        for (int i = 0; i < 32; i++) begin
            imem[i] = '0;
            gpr[i]  = '0;
        end
        pc = '0;
    end

    assign instr = imem[pc];

    always @(posedge clock) begin
        if (im_we) imem[im_waddr] <= im_wdata;
        if (!cpu_reset) begin
            pc <= '0;
        end else begin
            case (instr[31:26])
                6'h08: if (instr[20:16] != '0)
                           gpr[instr[20:16]] <= gpr[instr[25:21]] + {{16{instr[15]}}, instr[15:0]};
                6'h00: if (instr[5:0] == 6'h20 && instr[15:11] != '0)
                           gpr[instr[15:11]] <= gpr[instr[25:21]] + gpr[instr[20:16]];
                default: ;
            endcase
            pc <= (instr[31:26] == 6'h02) ? instr[AW-1:0] : pc + AW'(1);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected instruction-memory writes
    logic [AW+DW-1:0] exp_wq [$];
    logic             cpu2_seen = 1'b0;

    always @(negedge clock) begin
        if (reset && im_we) begin
            if (exp_wq.size() == 0) check("im_we_unexpected", 64'd1, 64'd0);
            else check("im_write", {im_waddr, im_wdata}, exp_wq.pop_front());
        end
        if (cpu_reset2) cpu2_seen <= 1'b1;
    end

    logic [DW-1:0] prog_a [4];
    logic [DW-1:0] prog_b [4];

    typedef struct {
        int            sel;
        bit            gaps;
        logic [CW-1:0] limit;
        logic [1:0]    cause;
        logic [CW-1:0] cyc;
        logic [DW-1:0] g1;
        logic [DW-1:0] g2;
        logic [DW-1:0] g3;
    } vec_t;

    vec_t vecs [6];

    task automatic start_run(input string tag);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, "_load_ready"}, load_ready, 1);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_done_clear"}, done, 0);
        check({tag, "_cycles_clear"}, cycles, 0);
        check({tag, "_cause_clear"}, halt_cause, 0);
    endtask

    task automatic load_words(input int sel, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                load_valid = 1'b0;
                load_data  = 32'hdeadbeef;
                load_last  = 1'b1;
                @(posedge clock); #1;
            end
            load_valid = 1'b1;
            load_data  = (sel == 0) ? prog_a[i] : prog_b[i];
            load_last  = (i == n - 1);
            exp_wq.push_back({AW'(i), load_data});
            @(posedge clock); #1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 200) begin
            @(posedge clock); #1;
            k++;
        end
        check({tag, "_done_reached"}, done, 1);
    endtask

    initial begin
        prog_a = '{32'h2001ffff, 32'h20020064, 32'h00221820, 32'h0000000C};
        prog_b = '{32'h20010001, 32'h00210820, 32'h08000000, 32'h00000000};
        //          sel gaps limit  cause cyc    g1            g2      g3
        vecs[0] = '{0, 1'b0, 16'd0,  2'd1, 16'd3,  32'hffffffff, 32'd100, 32'd99};
        vecs[1] = '{0, 1'b1, 16'd0,  2'd1, 16'd3,  32'hffffffff, 32'd100, 32'd99};
        vecs[2] = '{1, 1'b0, 16'd10, 2'd2, 16'd10, 32'd1,        32'd100, 32'd99};
        vecs[3] = '{0, 1'b0, 16'd4,  2'd1, 16'd3,  32'hffffffff, 32'd100, 32'd99};
        vecs[4] = '{0, 1'b0, 16'd3,  2'd2, 16'd3,  32'hffffffff, 32'd100, 32'd99};
        vecs[5] = '{0, 1'b0, 16'd1,  2'd2, 16'd1,  32'hffffffff, 32'd100, 32'd99};

        #2 reset = 1'b0;
        #1;
        check("rst_load_ready", load_ready, 0);
        check("rst_im_we", im_we, 0);
        check("rst_im_waddr", im_waddr, 0);
        check("rst_cpu_reset", cpu_reset, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cause", halt_cause, 0);
        check("rst_cycles", cycles, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        for (int v = 0; v < 6; v++) begin
            cycle_limit = vecs[v].limit;
            start_run($sformatf("v%0d_start", v));
            load_words(vecs[v].sel, (vecs[v].sel == 0) ? 4 : 3, vecs[v].gaps);
            check($sformatf("v%0d_cpu_released", v), cpu_reset, 1);
            check($sformatf("v%0d_ready_dropped", v), load_ready, 0);
            wait_done($sformatf("v%0d", v));
            check($sformatf("v%0d_cause", v), halt_cause, vecs[v].cause);
            check($sformatf("v%0d_cycles", v), cycles, vecs[v].cyc);
            check($sformatf("v%0d_cpu_held", v), cpu_reset, 0);
            check($sformatf("v%0d_busy", v), busy, 0);
            @(posedge clock); #1;
            check($sformatf("v%0d_gpr1", v), gpr[1], vecs[v].g1);
            check($sformatf("v%0d_gpr2", v), gpr[2], vecs[v].g2);
            check($sformatf("v%0d_gpr3", v), gpr[3], vecs[v].g3);
            check($sformatf("v%0d_done_holds", v), done, 1);
        end

        // Reset in the middle of an unlimited looping run, with start ignored in RUN
        cycle_limit = '0;
        start_run("mid_start");
        load_words(1, 3, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("run_start_ignored_busy", busy, 1);
        check("run_start_ignored_cpu", cpu_reset, 1);
        check("run_cycles_count", cycles, 6);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_cpu_reset", cpu_reset, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cycles", cycles, 0);
        check("mid_rst_im_waddr", im_waddr, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ready", load_ready, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        start_run("after_rst_start");
        load_words(0, 4, 1'b0);
        wait_done("after_rst");
        check("after_rst_cause", halt_cause, 1);
        check("after_rst_cycles", cycles, 3);

        // Load overflow on the 4-word instance
        cycle_limit = 16'd2;
        start2 = 1'b1;
        @(posedge clock); #1;
        start2 = 1'b0;
        check("ovf_ready", load_ready2, 1);
        for (int i = 0; i < 4; i++) begin
            load_valid2 = 1'b1;
            load_data   = 32'h100 + i;
            load_last   = 1'b0;
            #1;
            check($sformatf("ovf_we_%0d", i), im_we2, 1);
            check($sformatf("ovf_addr_%0d", i), im_waddr2, i);
            @(posedge clock); #1;
        end
        load_valid2 = 1'b0;
        check("ovf_done", done2, 1);
        check("ovf_cause", halt_cause2, 3);
        check("ovf_busy", busy2, 0);
        check("ovf_cpu_held", cpu_reset2, 0);
        @(posedge clock); #1;
        check("ovf_cpu_never_released", cpu2_seen, 0);

        // Last word exactly on the top address is a normal load
        start2 = 1'b1;
        @(posedge clock); #1;
        start2 = 1'b0;
        check("top_restart_cause_clear", halt_cause2, 0);
        check("top_restart_ready", load_ready2, 1);
        for (int i = 0; i < 4; i++) begin
            load_valid2 = 1'b1;
            load_data   = 32'h200 + i;
            load_last   = (i == 3);
            @(posedge clock); #1;
        end
        load_valid2 = 1'b0;
        load_last   = 1'b0;
        check("top_run", cpu_reset2, 1);
        check("top_not_done", done2, 0);
        for (int k = 0; k < 50 && !done2; k++) begin
            @(posedge clock); #1;
        end
        check("top_done", done2, 1);
        check("top_cause", halt_cause2, 2);
        check("top_cycles", cycles2, 2);

        check("write_queue_drained", exp_wq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the single-cycle CPU. It holds the CPU in reset and streams a program into instruction memory over a valid/ready port. It then releases the CPU and runs it until it fetches a halt instruction or hits a cycle limit, and reports completion and cause. It sits between the test/host side and the `s_cycle_cpu` instance, and drives the CPU's `reset` and the instruction-memory write port.

## Interface

- `ADDR_WIDTH`, 5: instruction-memory word-address width; depth = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: instruction word width.
- `CNT_WIDTH`, 16: cycle counter / limit width.
- `HALT_INSTR`, 32'h0000000C: instruction encoding (syscall) that terminates a run.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin load+run; sampled only in IDLE or DONE.
- `load_valid`  in  1  program word present.
- `load_ready`  out  1  controller accepts a word.
- `load_data`  in  DATA_WIDTH  program word.
- `load_last`  in  1  marks final program word.
- `im_we`  out  1  instruction-memory write enable.
- `im_waddr`  out  ADDR_WIDTH  instruction-memory word address.
- `im_wdata`  out  DATA_WIDTH  instruction-memory write data.
- `cpu_reset`  out  1  drives CPU `reset`; active-low, 0 = CPU held.
- `instr`  in  DATA_WIDTH  CPU's current fetched instruction.
- `cycle_limit`  in  CNT_WIDTH  max executed instructions; 0 = unlimited.
- `busy`  out  1  in LOAD or RUN.
- `done`  out  1  in DONE.
- `halt_cause`  out  2  0 none, 1 halt instr, 2 cycle limit, 3 load overflow.
- `cycles`  out  CNT_WIDTH  instructions executed in the current/last run.

## Operation

- States: IDLE, LOAD, RUN, DONE. Reset forces IDLE.
- IDLE: `start` → LOAD; `waddr`←0, `cycles`←0, `halt_cause`←0.
- LOAD: `load_ready`=1. Handshake = `load_valid & load_ready`.
  - `im_we` = handshake (combinational); `im_wdata`=`load_data`; `im_waddr`=write counter. The memory writes on the same edge.
  - On handshake the counter increments.
  - Handshake with `load_last` → RUN.
  - Handshake without `load_last` at address 2^ADDR_WIDTH−1 → DONE, cause 3. The CPU is never released.
  - Overflow with `load_last` on the final address → RUN (normal).
- RUN: `cpu_reset`=1. CPU starts from its reset PC (0). Each edge:
  - `instr`==HALT_INSTR → DONE, cause 1, `cycles` unchanged (halt not counted).
  - else `cycles`←`cycles`+1. If `cycle_limit`≠0 and `cycles`+1==`cycle_limit` → DONE, cause 2.
  - Halt wins over limit in the same cycle.
  - With limit 0, `cycles` saturates at all-ones and the run continues.
- DONE: `done`=1, `cpu_reset`=0, outputs hold. `start` → LOAD with the same clearing as IDLE.
- `start` is ignored in LOAD and RUN. `load_valid` is ignored outside LOAD.
- `cycle_limit` is sampled live. Changing it mid-run takes effect next edge.

## Timing

- Async reset (`reset`=0) immediately sets: state IDLE, `load_ready`=0, `im_we`=0, `im_waddr`=0, `cpu_reset`=0, `busy`=0, `done`=0, `halt_cause`=0, `cycles`=0.
- `cpu_reset`, `busy`, `done`, `load_ready`, `halt_cause`, `cycles` are registered state decodes. They change only on `clock` rising edges, except under async reset.
- `im_we` is combinational from `load_valid` and registered `load_ready`.
- Latencies:
  - `start` edge → `load_ready`=1 next cycle.
  - Last handshake edge → `cpu_reset`=1 next cycle. The first CPU instruction executes on the following edge.
  - Halt detection edge → `done`=1 and `cpu_reset`=0 next cycle.
- Reset mid-LOAD or mid-RUN aborts. The CPU is held and partial instruction-memory contents are left as written.

## Test plan

- Normal run:
  - Stimulus: load 2001ffff, 20020064, 00221820, 0000000C, with `load_last` on word 4 and `cycle_limit`=0.
  - Required: writes to addr 0..3; RUN; `done`=1 with `cycles`=3, `halt_cause`=1; CPU GPR1=−1, GPR2=100, GPR3=99.
- Backpressure:
  - Stimulus: same program with `load_valid` deasserted on alternate cycles.
  - Required: `im_we` pulses only on handshakes; addresses contiguous 0..3; identical final result.
- Cycle limit:
  - Stimulus: 3-word program with no halt, `cycle_limit`=10.
  - Required: `done` with `cycles`=10, `halt_cause`=2, `cpu_reset`=0 in DONE.
- Load overflow:
  - Stimulus: `ADDR_WIDTH`=2, four words with no `load_last`.
  - Required: DONE, `halt_cause`=3; `cpu_reset` never 1.
- Reset mid-run:
  - Stimulus: drive `reset` low for 1 cycle during RUN.
  - Required: all outputs take reset values asynchronously; `start` afterwards reloads and completes normally.
- Restart from DONE:
  - Stimulus: `start` in DONE.
  - Required: `cycles` and `halt_cause` clear; `load_ready`=1 next cycle.
